fmc_mux_initiator: RTL and testbench

// - FMC host-side initiator: drives STM32-style synchronous multiplexed AD[15:0] bus (NE/NADV/NOE/NWE/NBL/NWAIT).
// - Counterpart of the FPGA-side FMC-to-APB bridge. Used as an FPGA-to-FPGA link master and as the bridge's bench driver.
// - Single command in flight. Writes: 32-bit or 64-bit. Reads: 32-bit only.

---
 rtl/fmc_mux_initiator.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_fmc_mux_initiator.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fmc_mux_initiator.sv
// Host-side initiator for the synchronous multiplexed FMC AD bus, one command in flight.
// Define FMC_INITIATOR_TIMEOUT_EN to abort a command after TIMEOUT_CYCLES consecutive NWAIT-low clocks.
//
// state | meaning
// IDLE  | cmd_ready high, bus parked
// ADDR  | NE/NADV low, address on AD
// LAT   | latency padding between address phase and first data clock
// DATA  | one beat per clock with NWAIT high, held while NWAIT low
// END   | CS# held low for burst-end dummy clocks, rsp on the last one
// TURN  | CS# high turnaround before the next accept
module fmc_mux_initiator #(
   parameter int DATLAT    = 1,
   parameter int END_DUMMY = 2,
   parameter int BUSTURN   = 1
`ifdef FMC_INITIATOR_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 256
`endif
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic        cmd_x64,
   input  logic [25:0] cmd_addr,
   input  logic [63:0] cmd_wdata,
   input  logic [7:0]  cmd_wstrb,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        fmc_cs_n,
   output logic        fmc_nadv,
   output logic        fmc_noe,
   output logic        fmc_nwe,
   output logic [1:0]  fmc_nbl,
   output logic [9:0]  fmc_a_hi,
   output logic [15:0] fmc_ad_out,
   output logic        fmc_ad_oe,
   input  logic [15:0] fmc_ad_in,
   input  logic        fmc_nwait
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_ADDR = 3'd1;
   localparam logic [2:0] S_LAT  = 3'd2;
   localparam logic [2:0] S_DATA = 3'd3;
   localparam logic [2:0] S_END  = 3'd4;
   localparam logic [2:0] S_TURN = 3'd5;

   logic [2:0]  state, state_nxt;
   logic [7:0]  cnt, cnt_nxt;
   logic [1:0]  beat, beat_nxt, last_beat, lane;
   logic        accept;
   logic        write_q, write_n, x64_q, x64_n;
   logic [25:1] addr_q, addr_n;
   logic [63:0] wdata_q, wdata_n;
   logic [7:0]  wstrb_q, wstrb_n;
   logic [31:0] rdata_q, rdata_nxt;
   logic        cs_n_d, nadv_d, noe_d, nwe_d, ad_oe_d, rsp_valid_d;
   logic [1:0]  nbl_d;
   logic [9:0]  a_hi_d;
   logic [15:0] ad_out_d;
   logic [31:0] rsp_rdata_d;
   logic        unused_addr0;
`ifdef FMC_INITIATOR_TIMEOUT_EN
   logic [15:0] wait_cnt, wait_nxt;
   logic        err_q, err_nxt;
`endif

   // Byte address bit 0 has no pin on a 16-bit bus.
   assign unused_addr0 = cmd_addr[0];
   assign accept       = (state == S_IDLE) && cmd_valid && cmd_ready;
   assign last_beat    = (write_q && x64_q) ? 2'd3 : 2'd1;

   always_comb begin
      write_n = write_q;
      x64_n   = x64_q;
      addr_n  = addr_q;
      wdata_n = wdata_q;
      wstrb_n = wstrb_q;
      if (accept) begin
         write_n = cmd_write;
         x64_n   = cmd_x64;
         addr_n  = cmd_addr[25:1];
         wdata_n = cmd_wdata;
         wstrb_n = cmd_wstrb;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      beat_nxt  = beat;
      rdata_nxt = rdata_q;
`ifdef FMC_INITIATOR_TIMEOUT_EN
      wait_nxt  = wait_cnt;
      err_nxt   = err_q;
`endif
      case (state)
         S_IDLE: begin
            if (accept) begin
               state_nxt = S_ADDR;
               beat_nxt  = 2'd0;
               rdata_nxt = '0;
`ifdef FMC_INITIATOR_TIMEOUT_EN
               wait_nxt  = '0;
               err_nxt   = 1'b0;
`endif
            end
         end
         S_ADDR: begin
            if (DATLAT > 1) begin
               state_nxt = S_LAT;
               cnt_nxt   = 8'(DATLAT - 2);
            end else begin
               state_nxt = S_DATA;
            end
         end
         S_LAT: begin
            if (cnt == '0) state_nxt = S_DATA;
            else           cnt_nxt   = cnt - 8'd1;
         end
         S_DATA: begin
            if (fmc_nwait) begin
               if (!write_q) begin
                  if (beat[0]) rdata_nxt[31:16] = fmc_ad_in;
                  else         rdata_nxt[15:0]  = fmc_ad_in;
               end
               if (beat == last_beat) begin
                  state_nxt = S_END;
                  cnt_nxt   = 8'(END_DUMMY - 1);
               end else begin
                  beat_nxt = beat + 2'd1;
               end
            end
         end
         S_END: begin
            if (cnt == '0) begin
               state_nxt = S_TURN;
               cnt_nxt   = 8'(BUSTURN - 1);
            end else begin
               cnt_nxt = cnt - 8'd1;
            end
         end
         S_TURN: begin
            if (cnt == '0) state_nxt = S_IDLE;
            else           cnt_nxt   = cnt - 8'd1;
         end
         default: state_nxt = S_IDLE;
      endcase
`ifdef FMC_INITIATOR_TIMEOUT_EN
      // A stalled target overrides whatever LAT/DATA decided above.
      if (state == S_LAT || state == S_DATA) begin
         if (fmc_nwait) begin
            wait_nxt = '0;
         end else begin
            wait_nxt = wait_cnt + 16'd1;
            if (wait_nxt == 16'(TIMEOUT_CYCLES)) begin
               state_nxt = S_END;
               cnt_nxt   = 8'(END_DUMMY - 1);
               rdata_nxt = '0;
               err_nxt   = 1'b1;
            end
         end
      end
`endif
   end

   // Pad values are decoded from the next state so every output leaves a flop.
   always_comb begin
      lane     = x64_n ? (beat_nxt ^ 2'b10) : beat_nxt;
      cs_n_d   = 1'b1;
      nadv_d   = 1'b1;
      noe_d    = 1'b1;
      nwe_d    = 1'b1;
      nbl_d    = 2'b11;
      ad_oe_d  = 1'b0;
      ad_out_d = '0;
      a_hi_d   = '0;
      case (state_nxt)
         S_ADDR: begin
            cs_n_d   = 1'b0;
            nadv_d   = 1'b0;
            nwe_d    = !write_n;
            nbl_d    = 2'b00;
            ad_oe_d  = 1'b1;
            ad_out_d = addr_n[16:1];
            a_hi_d   = {1'b0, addr_n[25:17]};
         end
         S_LAT, S_DATA: begin
            cs_n_d = 1'b0;
            nwe_d  = !write_n;
            a_hi_d = {1'b0, addr_n[25:17]};
            if (write_n) begin
               ad_oe_d = 1'b1;
               case (lane)
                  2'd0: begin ad_out_d = wdata_n[15:0];  nbl_d = ~wstrb_n[1:0]; end
                  2'd1: begin ad_out_d = wdata_n[31:16]; nbl_d = ~wstrb_n[3:2]; end
                  2'd2: begin ad_out_d = wdata_n[47:32]; nbl_d = ~wstrb_n[5:4]; end
                  2'd3: begin ad_out_d = wdata_n[63:48]; nbl_d = ~wstrb_n[7:6]; end
               endcase
            end else begin
               noe_d = 1'b0;
               nbl_d = 2'b00;
            end
         end
         S_END: begin
            cs_n_d = 1'b0;
            a_hi_d = {1'b0, addr_n[25:17]};
         end
         default: ;
      endcase
      rsp_valid_d = (state_nxt == S_END) && (cnt_nxt == '0);
      rsp_rdata_d = rsp_valid_d ? rdata_nxt : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         cnt        <= '0;
         beat       <= '0;
         write_q    <= 1'b0;
         x64_q      <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         rdata_q    <= '0;
         cmd_ready  <= 1'b1;
         rsp_valid  <= 1'b0;
         rsp_rdata  <= '0;
         fmc_cs_n   <= 1'b1;
         fmc_nadv   <= 1'b1;
         fmc_noe    <= 1'b1;
         fmc_nwe    <= 1'b1;
         fmc_nbl    <= 2'b11;
         fmc_a_hi   <= '0;
         fmc_ad_out <= '0;
         fmc_ad_oe  <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         beat       <= beat_nxt;
         write_q    <= write_n;
         x64_q      <= x64_n;
         addr_q     <= addr_n;
         wdata_q    <= wdata_n;
         wstrb_q    <= wstrb_n;
         rdata_q    <= rdata_nxt;
         cmd_ready  <= (state_nxt == S_IDLE);
         rsp_valid  <= rsp_valid_d;
         rsp_rdata  <= rsp_rdata_d;
         fmc_cs_n   <= cs_n_d;
         fmc_nadv   <= nadv_d;
         fmc_noe    <= noe_d;
         fmc_nwe    <= nwe_d;
         fmc_nbl    <= nbl_d;
         fmc_a_hi   <= a_hi_d;
         fmc_ad_out <= ad_out_d;
         fmc_ad_oe  <= ad_oe_d;
      end
   end

`ifdef FMC_INITIATOR_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt <= '0;
         err_q    <= 1'b0;
         rsp_err  <= 1'b0;
      end else begin
         wait_cnt <= wait_nxt;
         err_q    <= err_nxt;
         rsp_err  <= rsp_valid_d & err_nxt;
      end
   end
`else
   assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_fmc_mux_initiator.sv
// Directed bench for fmc_mux_initiator: vector table of single commands plus
// hand sequences for back-to-back, NWAIT timeout (or indefinite wait) and mid-command reset.
module tb_fmc_mux_initiator;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_write = 1'b0;
   logic        cmd_x64 = 1'b0;
   logic [25:0] cmd_addr = '0;
   logic [63:0] cmd_wdata = '0;
   logic [7:0]  cmd_wstrb = '0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        fmc_cs_n, fmc_nadv, fmc_noe, fmc_nwe, fmc_ad_oe;
   logic [1:0]  fmc_nbl;
   logic [9:0]  fmc_a_hi;
   logic [15:0] fmc_ad_out;
   logic [15:0] fmc_ad_in = '0;
   logic        fmc_nwait = 1'b1;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   fmc_mux_initiator #(
      .DATLAT(1), .END_DUMMY(2), .BUSTURN(1)
`ifdef FMC_INITIATOR_TIMEOUT_EN
      , .TIMEOUT_CYCLES(8)
`endif
   ) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_x64(cmd_x64),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .fmc_cs_n(fmc_cs_n), .fmc_nadv(fmc_nadv), .fmc_noe(fmc_noe), .fmc_nwe(fmc_nwe),
      .fmc_nbl(fmc_nbl), .fmc_a_hi(fmc_a_hi), .fmc_ad_out(fmc_ad_out), .fmc_ad_oe(fmc_ad_oe),
      .fmc_ad_in(fmc_ad_in), .fmc_nwait(fmc_nwait)
   );

   typedef struct {
      logic             write;
      logic             x64;
      logic [25:0]      addr;
      logic [63:0]      wdata;
      logic [7:0]       wstrb;
      logic [1:0][15:0] rd;        // target read beats {k1,k0}
      int               stall_beat;
      int               stall_len;
      logic [15:0]      exp_ad;
      logic [9:0]       exp_ahi;
      logic [3:0][15:0] exp_beat;  // {k3,k2,k1,k0}
      logic [3:0][1:0]  exp_nbl;
      logic [31:0]      exp_rdata;
      int               exp_rsp;   // clocks from accept to rsp_valid
   } vec_t;

   vec_t vecs[5];

   function automatic vec_t mk(logic wr, logic x64, logic [25:0] a, logic [63:0] wd, logic [7:0] ws,
                               logic [31:0] rd, int sb, int sl, logic [15:0] ead, logic [9:0] eahi,
                               logic [63:0] ebeat, logic [7:0] enbl, logic [31:0] erd, int ersp);
      vec_t v;
      v.write = wr; v.x64 = x64; v.addr = a; v.wdata = wd; v.wstrb = ws; v.rd = rd;
      v.stall_beat = sb; v.stall_len = sl; v.exp_ad = ead; v.exp_ahi = eahi;
      v.exp_beat = ebeat; v.exp_nbl = enbl; v.exp_rdata = erd; v.exp_rsp = ersp;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic string nm(int i, string s);
      return $sformatf("v%0d_%s", i, s);
   endfunction

   task automatic issue(input logic wr, input logic x64, input logic [25:0] a,
                        input logic [63:0] wd, input logic [7:0] ws);
      cmd_valid = 1'b1; cmd_write = wr; cmd_x64 = x64; cmd_addr = a; cmd_wdata = wd; cmd_wstrb = ws;
   endtask

   // Called at a negedge in IDLE; returns at a negedge in IDLE.
   task automatic run_cmd(input int idx, input vec_t v);
      int nb, k, stall_left, cyc, rsp_cyc;
      nb = (v.write && v.x64) ? 4 : 2;
      stall_left = v.stall_len;
      chk(nm(idx, "ready"), cmd_ready, 1);
      issue(v.write, v.x64, v.addr, v.wdata, v.wstrb);
      @(negedge clk);
      cmd_valid = 1'b0;
      cyc = 1;
      chk(nm(idx, "addr_strb"), {fmc_cs_n, fmc_nadv, fmc_ad_oe, fmc_nwe, fmc_nbl},
          {3'b001, !v.write, 2'b00});
      chk(nm(idx, "addr_ad"), fmc_ad_out, v.exp_ad);
      chk(nm(idx, "a_hi"), fmc_a_hi, v.exp_ahi);
      chk(nm(idx, "busy"), cmd_ready, 0);
      k = 0;
      for (int c = 0; c < 64 && k < nb; c++) begin
         @(negedge clk);
         cyc++;
         if (v.write)
            chk(nm(idx, $sformatf("wbeat%0d", k)), {fmc_cs_n, fmc_nadv, fmc_nwe, fmc_ad_oe, fmc_nbl, fmc_ad_out},
                {4'b0101, v.exp_nbl[k], v.exp_beat[k]});
         else
            chk(nm(idx, $sformatf("rbeat%0d", k)), {fmc_cs_n, fmc_nadv, fmc_noe, fmc_ad_oe, fmc_nbl}, 6'b010000);
         if (k == v.stall_beat && stall_left > 0) begin
            fmc_nwait = 1'b0;
            fmc_ad_in = ~v.rd[k % 2];
            stall_left--;
         end else begin
            fmc_nwait = 1'b1;
            fmc_ad_in = v.rd[k % 2];
            k++;
         end
      end
      @(negedge clk);
      cyc++;
      fmc_nwait = 1'b1;
      fmc_ad_in = 16'h0;
      chk(nm(idx, "end_strb"), {fmc_cs_n, fmc_noe, fmc_nwe, fmc_ad_oe}, 4'b0110);
      rsp_cyc = -1;
      for (int c = 0; c < 8; c++) begin
         if (rsp_valid) begin
            rsp_cyc = cyc;
            break;
         end
         @(negedge clk);
         cyc++;
      end
      chk(nm(idx, "rsp_cycle"), 64'(rsp_cyc), 64'(v.exp_rsp));
      chk(nm(idx, "rdata"), rsp_rdata, v.exp_rdata);
      chk(nm(idx, "err"), rsp_err, 0);
      @(negedge clk);
      chk(nm(idx, "turn"), {fmc_cs_n, rsp_valid, cmd_ready}, 3'b100);
      @(negedge clk);
      chk(nm(idx, "idle"), {fmc_cs_n, cmd_ready}, 2'b11);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int rsp_at, acc2, cs_hi, gap, cnt;

      // Beat order for 64-bit writes is [47:32],[63:48],[15:0],[31:16].
      vecs[0] = mk(0, 0, 26'h0000124, 64'h0, 8'h00, 32'hDEAD_BEEF, -1, 0,
                   16'h0092, 10'h000, 64'h0, 8'h00, 32'hDEAD_BEEF, 5);
      vecs[1] = mk(1, 1, 26'h0800010, 64'h1111_2222_3333_4444, 8'hF3, 32'h0, -1, 0,
                   16'h0008, 10'h040, 64'h3333_4444_1111_2222, 8'b11_00_00_00, 32'h0, 7);
      vecs[2] = mk(1, 0, 26'h3FFFFFF, 64'hFFFF_FFFF_CAFE_F00D, 8'h0E, 32'h0, -1, 0,
                   16'hFFFF, 10'h1FF, 64'h0000_0000_CAFE_F00D, 8'b00_00_00_01, 32'h0, 5);
      vecs[3] = mk(1, 0, 26'h0001000, 64'h0000_0000_A5A5_5A5A, 8'h0F, 32'h0, 1, 3,
                   16'h0800, 10'h000, 64'h0000_0000_A5A5_5A5A, 8'h00, 32'h0, 8);
      vecs[4] = mk(0, 1, 26'h2000002, 64'h0, 8'h00, 32'h5678_1234, 0, 2,
                   16'h0001, 10'h100, 64'h0, 8'h00, 32'h5678_1234, 7);

      repeat (3) @(negedge clk);
      chk("rst_strobes", {fmc_cs_n, fmc_nadv, fmc_noe, fmc_nwe, fmc_nbl, fmc_ad_oe}, 7'b1111110);
      chk("rst_bus", {fmc_ad_out, fmc_a_hi}, 26'h0);
      chk("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 34'h0);
      chk("rst_ready", cmd_ready, 1);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 5; i++) run_cmd(i, vecs[i]);

      // Back-to-back reads with cmd_valid held high.
      fmc_nwait = 1'b1;
      fmc_ad_in = 16'h7E57;
      issue(0, 0, 26'h0000040, 64'h0, 8'h00);
      rsp_at = -1; acc2 = -1; cs_hi = 0; gap = -1;
      for (int c = 0; c < 40; c++) begin
         if (acc2 >= 0 && c > acc2) cmd_valid = 1'b0;
         if (rsp_valid && rsp_at < 0) begin
            rsp_at = c;
            chk("b2b_rdata", rsp_rdata, 32'h7E57_7E57);
         end
         if (rsp_at >= 0 && acc2 < 0 && cmd_ready && cmd_valid) acc2 = c;
         if (fmc_cs_n) cs_hi++;
         else begin
            if (rsp_at >= 0 && cs_hi > 0 && gap < 0) gap = cs_hi;
            cs_hi = 0;
         end
         if (gap >= 0) break;
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      chk("b2b_rsp_at", 64'(rsp_at), 5);
      chk("b2b_accept_gap", 64'(acc2 - rsp_at), 2);
      chk("b2b_cs_high", 64'(gap), 2);
      cnt = 0;
      for (int c = 0; c < 20 && cnt == 0; c++) begin
         @(negedge clk);
         if (rsp_valid) begin
            cnt++;
            chk("b2b_rdata2", rsp_rdata, 32'h7E57_7E57);
         end
      end
      chk("b2b_rsp2", 64'(cnt), 1);
      repeat (3) @(negedge clk);

      // Target stuck in wait.
      fmc_nwait = 1'b0;
      issue(0, 0, 26'h0000200, 64'h0, 8'h00);
      @(negedge clk);
      cmd_valid = 1'b0;
`ifdef FMC_INITIATOR_TIMEOUT_EN
      rsp_at = -1;
      for (int c = 1; c < 40; c++) begin
         if (rsp_valid) begin
            rsp_at = c;
            break;
         end
         @(negedge clk);
      end
      chk("to_rsp_at", 64'(rsp_at), 11);
      chk("to_err", rsp_err, 1);
      chk("to_rdata", rsp_rdata, 32'h0);
      fmc_nwait = 1'b1;
      repeat (3) @(negedge clk);
`else
      cnt = 0;
      for (int c = 0; c < 1000; c++) begin
         @(negedge clk);
         if (rsp_valid) cnt++;
      end
      chk("nto_no_rsp", 64'(cnt), 0);
      chk("nto_pending", {fmc_cs_n, cmd_ready}, 2'b00);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      fmc_nwait = 1'b1;
      @(negedge clk);
`endif

      // Reset in the first DATA clock of a read.
      issue(0, 0, 26'h0000124, 64'h0, 8'h00);
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      chk("rstd_in_data", fmc_noe, 0);
      fmc_ad_in = 16'h1111;
      rst = 1'b1;
      @(negedge clk);
      chk("rstd_strobes", {fmc_cs_n, fmc_nadv, fmc_noe, fmc_nwe, fmc_nbl, fmc_ad_oe}, 7'b1111110);
      chk("rstd_rsp", rsp_valid, 0);
      rst = 1'b0;
      cnt = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (rsp_valid) cnt++;
      end
      chk("rstd_dropped", 64'(cnt), 0);
      run_cmd(5, vecs[0]);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
